led_spi_master: RTL and testbench

SPI master for the LED driver link. Serialises one frame per start handshake: a 16-bit index/command word, a 64-bit init register word, or a 400-bit pixel data block. It simultaneously captures MISO into a 64-bit readback register. It sits directly under the LED SPI controller, which selects the frame type with `index`/`data` and sequences frames using `start`/`done`.

---
 rtl/led_spi_pkg.sv | 21 ++
 rtl/spi_sclk_gen.sv | 38 +++
 rtl/led_spi_master.sv | 102 ++++++++++
 tb/tb_led_spi_master.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_spi_pkg.sv
// Shared constants and state encoding for the LED link SPI master.
package led_spi_pkg;

    localparam int IDX_BITS  = 16;
    localparam int INIT_BITS = 64;
    localparam int PIX_BITS  = 400;

    // Bit counter must hold the longest frame length.
    localparam int CNT_W = 9;

    // The index command word is the top slice of the init word.
    localparam int IDX_HI = INIT_BITS - 1;
    localparam int IDX_LO = INIT_BITS - IDX_BITS;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: toggles sclk every HALF_PERIOD clks while enabled, flagging the edge about to happen.
// Ticks are combinational and coincide with the clk edge that flips sclk; disabling parks sclk low.
module spi_sclk_gen #(
    parameter int HALF_PERIOD = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sclk,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

    logic [CW-1:0] hp_cnt;
    logic          tick;

    assign tick      = en && (hp_cnt == CW'(HALF_PERIOD - 1));
    assign rise_tick = tick && !sclk;
    assign fall_tick = tick && sclk;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hp_cnt <= '0;
            sclk   <= 1'b0;
        end else if (!en) begin
            hp_cnt <= '0;
            sclk   <= 1'b0;
        end else if (tick) begin
            hp_cnt <= '0;
            sclk   <= ~sclk;
        end else begin
            hp_cnt <= hp_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/led_spi_master.sv
// Mode-0 SPI master: sends one 16/64/400-bit frame per start handshake and captures MISO into data_out.
// Frame takes 2*HALF_PERIOD*N clks after the latch edge; done holds until start drops.
module led_spi_master
    import led_spi_pkg::*;
#(
    parameter int HALF_PERIOD = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 index,
    input  logic                 data,
    input  logic [INIT_BITS-1:0] init_in,
    input  logic [PIX_BITS-1:0]  data_in,
    input  logic                 miso,
    output logic                 sclk,
    output logic                 mosi,
    output logic [INIT_BITS-1:0] data_out,
    output logic                 done
);

    state_t              state, state_nxt;
    logic [PIX_BITS-1:0] sr;
    logic [CNT_W-1:0]    bit_cnt;
    logic                rise_tick, fall_tick;
    logic                load;

    spi_sclk_gen #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_sclk_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (state == SHIFT),
        .sclk     (sclk),
        .rise_tick(rise_tick),
        .fall_tick(fall_tick)
    );

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (fall_tick && bit_cnt == CNT_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (!start) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Shorter frames are left-justified so the next bit out is always the top bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr       <= '0;
            bit_cnt  <= '0;
            data_out <= '0;
        end else if (load) begin
            if (index) begin
                sr      <= {init_in[IDX_HI:IDX_LO], {(PIX_BITS - IDX_BITS){1'b0}}};
                bit_cnt <= CNT_W'(IDX_BITS);
            end else if (data) begin
                sr      <= data_in;
                bit_cnt <= CNT_W'(PIX_BITS);
            end else begin
                sr      <= {init_in, {(PIX_BITS - INIT_BITS){1'b0}}};
                bit_cnt <= CNT_W'(INIT_BITS);
            end
        end else if (state == SHIFT) begin
            if (rise_tick) begin
                data_out <= {data_out[INIT_BITS-2:0], miso};
            end
            if (fall_tick) begin
                sr      <= {sr[PIX_BITS-2:0], 1'b0};
                bit_cnt <= bit_cnt - CNT_W'(1);
            end
        end
    end

    assign mosi = sr[PIX_BITS-1];
    assign done = (state == DONE);

endmodule

// File: tb/tb_led_spi_master.sv
// Randomized bench for led_spi_master against a bit-sequence reference model of each frame.
module tb_led_spi_master;

    localparam int HP = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         index = 1'b0;
    logic         data = 1'b0;
    logic         miso = 1'b0;
    logic [63:0]  init_in = '0;
    logic [399:0] data_in = '0;
    logic         sclk, mosi, done;
    logic [63:0]  data_out;

    int checks = 0;
    int errors = 0;
    bit miso_hist[$];

    always #5 clk = ~clk;

    led_spi_master #(.HALF_PERIOD(HP)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .index   (index),
        .data    (data),
        .init_in (init_in),
        .data_in (data_in),
        .miso    (miso),
        .sclk    (sclk),
        .mosi    (mosi),
        .data_out(data_out),
        .done    (done)
    );

    // Readback register is by definition the most recent 64 MISO bits since reset.
    function automatic logic [63:0] model_readback();
        logic [63:0] r;
        int n;
        r = '0;
        n = miso_hist.size();
        for (int i = 0; i < 64; i++) begin
            if (i < n) r[i] = miso_hist[n-1-i];
        end
        return r;
    endfunction

    task automatic run_frame(input bit idx, input bit dat, input logic [63:0] iw,
                             input logic [399:0] dw, input bit miso_fixed,
                             input logic [63:0] miso_word, input int abort_at,
                             input bit no_wait, input string name);
        bit exp_q[$];
        int n, rises, cyc;
        bit prev_sclk, prev_mosi, got_done, cur_miso;
        int mosi_bad;
        exp_q = {};
        if (idx) begin
            for (int i = 0; i < 16; i++) exp_q.push_back(iw[63-i]);
        end else if (dat) begin
            for (int i = 0; i < 400; i++) exp_q.push_back(dw[399-i]);
        end else begin
            for (int i = 0; i < 64; i++) exp_q.push_back(iw[63-i]);
        end
        n = exp_q.size();
        if (!no_wait) @(negedge clk);
        index = idx; data = dat; init_in = iw; data_in = dw; start = 1'b1;
        cur_miso = miso_fixed ? miso_word[63] : 1'($urandom);
        miso = cur_miso;
        @(posedge clk);
        cyc = 0; rises = 0; prev_sclk = 0; prev_mosi = 0; got_done = 0; mosi_bad = 0;
        while (cyc < 2*HP*n + 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                checks++;
                if (sclk !== 1'b0 || mosi !== exp_q[0]) begin
                    errors++;
                    $display("FAIL %s first_cycle sclk=%b mosi=%b expected sclk=0 mosi=%b",
                             name, sclk, mosi, exp_q[0]);
                end
                // Inputs are only sampled at the latch edge; scramble them now.
                index = 1'($urandom); data = 1'($urandom);
                init_in = {$urandom, $urandom};
                data_in = {13{$urandom}};
            end else if (mosi !== prev_mosi && !(prev_sclk && !sclk)) begin
                mosi_bad++;
            end
            if (sclk === 1'b1 && prev_sclk === 1'b0) begin
                if (rises == 0) begin
                    checks++;
                    if (cyc != 1 + HP) begin
                        errors++;
                        $display("FAIL %s first_rise cycle=%0d expected=%0d", name, cyc, 1 + HP);
                    end
                end
                checks++;
                if (rises >= n) begin
                    errors++;
                    $display("FAIL %s extra_rise rise=%0d expected_max=%0d", name, rises, n);
                end else if (mosi !== exp_q[rises]) begin
                    errors++;
                    $display("FAIL %s mosi_bit rise=%0d got=%b expected=%b",
                             name, rises, mosi, exp_q[rises]);
                end
                miso_hist.push_back(cur_miso);
                rises++;
                checks++;
                if (data_out !== model_readback()) begin
                    errors++;
                    $display("FAIL %s data_out_rise rise=%0d got=%h expected=%h",
                             name, rises, data_out, model_readback());
                end
                cur_miso = miso_fixed ? miso_word[63 - (rises % 64)] : 1'($urandom);
                miso = cur_miso;
                if (abort_at > 0 && rises == abort_at) begin
                    rst_n = 1'b0;
                    @(negedge clk);
                    checks++;
                    if (sclk !== 1'b0 || mosi !== 1'b0 || done !== 1'b0 || data_out !== 64'h0) begin
                        errors++;
                        $display("FAIL %s abort_reset sclk=%b mosi=%b done=%b data_out=%h expected all 0",
                                 name, sclk, mosi, done, data_out);
                    end
                    miso_hist.delete();
                    rst_n = 1'b1;
                    start = 1'b0;
                    @(negedge clk);
                    return;
                end
            end
            if (done === 1'b1) begin
                got_done = 1;
                break;
            end
            prev_sclk = sclk;
            prev_mosi = mosi;
        end
        checks++;
        if (!got_done || cyc != 1 + 2*HP*n) begin
            errors++;
            $display("FAIL %s done_time got_done=%0d cycle=%0d expected=%0d",
                     name, got_done, cyc, 1 + 2*HP*n);
        end
        checks++;
        if (rises != n) begin
            errors++;
            $display("FAIL %s rise_count got=%0d expected=%0d", name, rises, n);
        end
        checks++;
        if (sclk !== 1'b0) begin
            errors++;
            $display("FAIL %s sclk_at_done got=%b expected=0", name, sclk);
        end
        checks++;
        if (mosi_bad != 0) begin
            errors++;
            $display("FAIL %s mosi_stability changes_outside_fall=%0d expected=0", name, mosi_bad);
        end
        checks++;
        if (data_out !== model_readback()) begin
            errors++;
            $display("FAIL %s data_out_done got=%h expected=%h", name, data_out, model_readback());
        end
        if (miso_fixed) begin
            checks++;
            if (data_out !== miso_word) begin
                errors++;
                $display("FAIL %s readback_word got=%h expected=%h", name, data_out, miso_word);
            end
        end
    endtask

    // Holds start high (must not retrigger), then drops it for exactly one sampled edge.
    task automatic end_frame(input int hold, input string name);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b1 || sclk !== 1'b0) begin
                errors++;
                $display("FAIL %s done_hold cycle=%0d done=%b sclk=%b expected done=1 sclk=0",
                         name, i, done, sclk);
            end
        end
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s done_clear got=%b expected=0", name, done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (sclk !== 1'b0 || mosi !== 1'b0 || done !== 1'b0 || data_out !== 64'h0) begin
            errors++;
            $display("FAIL reset sclk=%b mosi=%b done=%b data_out=%h expected all 0",
                     sclk, mosi, done, data_out);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (sclk !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset sclk=%b done=%b expected 0 0", sclk, done);
        end
    endtask

    task automatic test_index_frame();
        run_frame(1, 0, 64'hAA10_0000_0000_0000, {13{$urandom}}, 0, 64'h0, 0, 0, "index");
        end_frame(4, "index");
    endtask

    task automatic test_init_frame();
        run_frame(0, 0, 64'hAA00_2000_F0CF_0107, '0, 0, 64'h0, 0, 1, "init");
        end_frame(10, "init");
    endtask

    task automatic test_pixel_frame();
        logic [399:0] pix;
        pix = '0;
        pix[399] = 1'b1;
        pix[0] = 1'b1;
        run_frame(0, 1, {$urandom, $urandom}, pix, 0, 64'h0, 0, 1, "pixel");
        end_frame(2, "pixel");
    endtask

    task automatic test_readback();
        run_frame(0, 0, {$urandom, $urandom}, '0, 1, 64'hDEADBEEF_01234567, 0, 1, "readback");
        end_frame(1, "readback");
    endtask

    task automatic test_priority();
        run_frame(1, 1, {$urandom, $urandom}, {13{$urandom}}, 0, 64'h0, 0, 1, "priority");
        end_frame(3, "priority");
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            int sel;
            sel = $urandom_range(0, 3);
            run_frame(sel == 0 || sel == 3, sel >= 2, {$urandom, $urandom}, {13{$urandom}},
                      0, 64'h0, 0, 1, "random");
            end_frame($urandom_range(0, 5), "random");
        end
    endtask

    task automatic test_reset_midframe();
        run_frame(0, 1, {$urandom, $urandom}, {13{$urandom}}, 0, 64'h0, 30, 1, "abort");
        run_frame(0, 1, {$urandom, $urandom}, {13{$urandom}}, 0, 64'h0, 0, 0, "after_abort");
        end_frame(2, "after_abort");
    endtask

    initial begin
        test_reset();
        test_index_frame();
        test_init_frame();
        test_pixel_frame();
        test_readback();
        test_priority();
        test_back_to_back();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
